// File: rtl/soc_it_wr_data_packer.sv
// Packs a narrow word stream into 128-bit SoC-IT write-data beats, padding the final
// partial beat of each transfer and stamping every beat with the transfer tag.
module soc_it_wr_data_packer #(
    parameter int unsigned     IN_W     = 32,
    parameter int unsigned     OUT_W    = 128,
    parameter logic [IN_W-1:0] PAD_WORD = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_src_rdy,
    output logic             in_dst_rdy,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    input  logic [3:0]       in_tag,
    output logic             master_datain_src_rdy,
    input  logic             master_datain_dst_rdy,
    output logic [3:0]       master_datain_tag,
    output logic [OUT_W-1:0] master_datain,
    output logic             xfer_done,
    output logic [15:0]      beat_cnt
);

    localparam int unsigned LANES = OUT_W / IN_W;
    localparam int unsigned LW    = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic {StIdle, StPack} state_e;

    state_e           state_q;
    logic [LW-1:0]    lane_q;
    logic [OUT_W-1:0] asm_q;
    logic [OUT_W-1:0] beat;
    logic [3:0]       tag_q;
    logic             rdy_en_q;
    logic             out_last_q;
    logic             word_acc;
    logic             beat_acc;
    logic             emit;
    int unsigned      lane_i;

    // rdy_en_q keeps in_dst_rdy low until the first clock edge after reset
    assign in_dst_rdy = rdy_en_q & (~master_datain_src_rdy | master_datain_dst_rdy);
    assign word_acc   = in_src_rdy & in_dst_rdy;
    assign beat_acc   = master_datain_src_rdy & master_datain_dst_rdy;
    assign emit       = word_acc & (in_last | (lane_q == LW'(LANES - 1)));
    assign lane_i     = 32'(lane_q);

    // Lanes below the current one come from the assembly register, the current lane takes
    // the incoming word and any lanes above it are padded.
    always_comb begin
        beat = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (k < lane_i) begin
                beat[k*IN_W +: IN_W] = asm_q[k*IN_W +: IN_W];
            end else if (k == lane_i) begin
                beat[k*IN_W +: IN_W] = in_data;
            end else begin
                beat[k*IN_W +: IN_W] = PAD_WORD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q               <= StIdle;
            lane_q                <= '0;
            asm_q                 <= '0;
            tag_q                 <= '0;
            rdy_en_q              <= 1'b0;
            out_last_q            <= 1'b0;
            master_datain_src_rdy <= 1'b0;
            master_datain_tag     <= '0;
            master_datain         <= '0;
            xfer_done             <= 1'b0;
            beat_cnt              <= '0;
        end else begin
            rdy_en_q  <= 1'b1;
            xfer_done <= beat_acc & out_last_q;
            if (beat_acc) begin
                beat_cnt <= beat_cnt + 16'd1;
            end

            // A new beat may load in the same cycle the held one leaves: no bubble
            if (emit) begin
                master_datain_src_rdy <= 1'b1;
                master_datain         <= beat;
                master_datain_tag     <= (state_q == StIdle) ? in_tag : tag_q;
                out_last_q            <= in_last;
            end else if (beat_acc) begin
                master_datain_src_rdy <= 1'b0;
            end

            if (word_acc) begin
                if (state_q == StIdle) begin
                    tag_q <= in_tag;
                end
                if (emit) begin
                    asm_q  <= '0;
                    lane_q <= '0;
                end else begin
                    asm_q  <= beat;
                    lane_q <= lane_q + 1'b1;
                end
                state_q <= in_last ? StIdle : StPack;
            end
        end
    end

endmodule

// File: tb/tb_soc_it_wr_data_packer.sv
// Bench for soc_it_wr_data_packer: directed vector table, backpressure and reset sequences,
// then randomized transfers scored against a chunk-and-pad reference model.
module tb_soc_it_wr_data_packer;

    localparam int IN_W  = 32;
    localparam int LANES = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_src_rdy;
    logic         in_dst_rdy;
    logic [31:0]  in_data;
    logic         in_last;
    logic [3:0]   in_tag;
    logic         master_datain_src_rdy;
    logic         master_datain_dst_rdy;
    logic [3:0]   master_datain_tag;
    logic [127:0] master_datain;
    logic         xfer_done;
    logic [15:0]  beat_cnt;

    soc_it_wr_data_packer #(
        .IN_W (IN_W),
        .OUT_W(128)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .in_src_rdy           (in_src_rdy),
        .in_dst_rdy           (in_dst_rdy),
        .in_data              (in_data),
        .in_last              (in_last),
        .in_tag               (in_tag),
        .master_datain_src_rdy(master_datain_src_rdy),
        .master_datain_dst_rdy(master_datain_dst_rdy),
        .master_datain_tag    (master_datain_tag),
        .master_datain        (master_datain),
        .xfer_done            (xfer_done),
        .beat_cnt             (beat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] data;
        logic [3:0]   tag;
        logic         last;
    } beat_t;

    typedef struct {
        logic [3:0]   tag;
        int           len;
        logic [31:0]  w[8];
        int           nb;
        logic [127:0] eb[2];
    } vec_t;

    beat_t exp_q[$];
    int    tests = 0;
    int    fails = 0;
    int    bp_mode = 0;   // 0: always ready, 1: hold off, 2: random

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: cut the transfer into LANES-word chunks, pad the tail with zero words
    task automatic push_model(input logic [3:0] tag, input logic [31:0] w[$]);
        beat_t b;
        for (int i = 0; i < w.size(); i += LANES) begin
            b.data = '0;
            b.tag  = tag;
            b.last = (i + LANES >= w.size());
            for (int k = 0; k < LANES; k++) begin
                if (i + k < w.size()) b.data[k*IN_W +: IN_W] = w[i+k];
            end
            exp_q.push_back(b);
        end
    endtask

    task automatic send(input logic [3:0] tag, input logic [31:0] w[$], input bit with_last,
                        input int gap_pct, output int stalls);
        int waited;
        stalls = 0;
        for (int i = 0; i < w.size(); i++) begin
            waited = 0;
            if (gap_pct > 0) begin
                while ($urandom_range(0, 99) < gap_pct) begin
                    in_src_rdy = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            in_src_rdy = 1'b1;
            in_data    = w[i];
            in_last    = with_last && (i == w.size() - 1);
            in_tag     = (i == 0) ? tag : 4'($urandom);
            @(negedge clk);
            while (!in_dst_rdy) begin
                stalls++;
                waited++;
                if (waited > 300) begin
                    tests++;
                    fails++;
                    $display("FAIL send_timeout: in_dst_rdy stuck at 0, expected 1 within 300");
                    in_src_rdy = 1'b0;
                    return;
                end
                @(negedge clk);
            end
            @(posedge clk);
            #1;
        end
        in_src_rdy = 1'b0;
        in_last    = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_in_dst_rdy"}, in_dst_rdy, 0);
        check({pfx, "_src_rdy"}, master_datain_src_rdy, 0);
        check({pfx, "_tag"}, master_datain_tag, 0);
        check({pfx, "_data"}, master_datain, 0);
        check({pfx, "_xfer_done"}, xfer_done, 0);
        check({pfx, "_beat_cnt"}, beat_cnt, 0);
    endtask

    // Downstream ready driver
    initial begin
        master_datain_dst_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                1:       master_datain_dst_rdy = 1'b0;
                2:       master_datain_dst_rdy = ($urandom_range(0, 3) != 0);
                default: master_datain_dst_rdy = 1'b1;
            endcase
        end
    end

    // Monitor: everything sampled on the falling edge predicts the next rising edge
    logic [15:0]  m_cnt;
    bit           m_done_exp;
    bit           hold_v;
    logic [127:0] hold_d;
    logic [3:0]   hold_t;
    int           since_rst;
    beat_t        got;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_cnt      = '0;
                m_done_exp = 1'b0;
                hold_v     = 1'b0;
                since_rst  = 0;
            end else begin
                if (since_rst > 0 && master_datain_dst_rdy) check("in_dst_rdy_open", in_dst_rdy, 1);
                since_rst++;
                check("xfer_done", xfer_done, m_done_exp);
                check("beat_cnt", beat_cnt, m_cnt);
                if (hold_v) begin
                    check("hold_valid", master_datain_src_rdy, 1);
                    check("hold_data", master_datain, hold_d);
                    check("hold_tag", master_datain_tag, hold_t);
                end
                hold_v     = master_datain_src_rdy && !master_datain_dst_rdy;
                hold_d     = master_datain;
                hold_t     = master_datain_tag;
                m_done_exp = 1'b0;
                if (master_datain_src_rdy && master_datain_dst_rdy) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_beat: got %h, expected no beat", master_datain);
                    end else begin
                        got = exp_q.pop_front();
                        check("beat_data", master_datain, got.data);
                        check("beat_tag", master_datain_tag, got.tag);
                        m_done_exp = got.last;
                    end
                    m_cnt = m_cnt + 16'd1;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t         vt[5];
    logic [31:0]  w[$];
    int           st;
    int           total_nb;
    beat_t        b;
    initial begin
        vt[0].tag = 4'h5; vt[0].len = 4; vt[0].nb = 1;
        vt[0].w   = '{32'h11, 32'h22, 32'h33, 32'h44, 0, 0, 0, 0};
        vt[0].eb  = '{128'h00000044_00000033_00000022_00000011, 128'h0};
        vt[1].tag = 4'hA; vt[1].len = 6; vt[1].nb = 2;
        vt[1].w   = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 0, 0};
        vt[1].eb  = '{128'h00000004_00000003_00000002_00000001,
                      128'h00000000_00000000_00000006_00000005};
        vt[2].tag = 4'h3; vt[2].len = 1; vt[2].nb = 1;
        vt[2].w   = '{32'hDEAD, 0, 0, 0, 0, 0, 0, 0};
        vt[2].eb  = '{128'h00000000_00000000_00000000_0000DEAD, 128'h0};
        vt[3].tag = 4'h1; vt[3].len = 5; vt[3].nb = 2;
        vt[3].w   = '{32'h101, 32'h102, 32'h103, 32'h104, 32'h105, 0, 0, 0};
        vt[3].eb  = '{128'h00000104_00000103_00000102_00000101,
                      128'h00000000_00000000_00000000_00000105};
        vt[4].tag = 4'h2; vt[4].len = 3; vt[4].nb = 1;
        vt[4].w   = '{32'h201, 32'h202, 32'h203, 0, 0, 0, 0, 0};
        vt[4].eb  = '{128'h00000000_00000203_00000202_00000201, 128'h0};

        rst        = 1'b0;
        in_src_rdy = 1'b0;
        in_data    = '0;
        in_last    = 1'b0;
        in_tag     = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst = 1'b1;
        #1;
        check("rdy_before_first_edge", in_dst_rdy, 0);
        @(posedge clk);
        #1;
        check("rdy_after_first_edge", in_dst_rdy, 1);

        // Directed table, back-to-back at full rate
        total_nb = 0;
        for (int v = 0; v < 5; v++) begin
            w.delete();
            for (int i = 0; i < vt[v].len; i++) w.push_back(vt[v].w[i]);
            for (int j = 0; j < vt[v].nb; j++) begin
                b.data = vt[v].eb[j];
                b.tag  = vt[v].tag;
                b.last = (j == vt[v].nb - 1);
                exp_q.push_back(b);
            end
            total_nb += vt[v].nb;
            send(vt[v].tag, w, 1'b1, 0, st);
            check($sformatf("vec%0d_stalls", v), st, 0);
        end
        drain("table_drain");
        check("table_beat_cnt", beat_cnt, total_nb);

        // Downstream held off with a beat pending
        bp_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        w.delete();
        for (int i = 1; i <= 8; i++) w.push_back(32'h300 + i);
        push_model(4'h7, w);
        fork
            send(4'h7, w, 1'b1, 0, st);
            begin
                repeat (14) @(posedge clk);
                #1;
                check("bp_in_dst_rdy", in_dst_rdy, 0);
                check("bp_valid", master_datain_src_rdy, 1);
                check("bp_data", master_datain, 128'h00000304_00000303_00000302_00000301);
                check("bp_tag", master_datain_tag, 4'h7);
                bp_mode = 0;
            end
        join
        drain("bp_drain");

        // Reset in the middle of a beat
        w.delete();
        w.push_back(32'h501);
        w.push_back(32'h502);
        send(4'h9, w, 1'b0, 0, st);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        w.delete();
        for (int i = 1; i <= 4; i++) w.push_back(32'h600 + i);
        b.data = 128'h00000604_00000603_00000602_00000601;
        b.tag  = 4'hC;
        b.last = 1'b1;
        exp_q.push_back(b);
        send(4'hC, w, 1'b1, 0, st);
        check("post_rst_stalls", st, 0);
        drain("post_rst_drain");
        check("post_rst_beat_cnt", beat_cnt, 1);

        // Randomized transfers with random gaps and backpressure
        bp_mode = 2;
        for (int t = 0; t < 40; t++) begin
            int          len;
            logic [3:0]  tg;
            len = $urandom_range(1, 11);
            tg  = 4'($urandom);
            w.delete();
            for (int i = 0; i < len; i++) w.push_back($urandom);
            push_model(tg, w);
            send(tg, w, 1'b1, 25, st);
        end
        bp_mode = 0;
        drain("rand_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/soc_it_wr_data_packer.md
Name: soc_it_wr_data_packer

Overview:
- Sits directly upstream of the SoC-IT master write-data port and drives master_datain_src_rdy, master_datain_tag and master_datain.
- Accepts a narrow word stream from a user engine and packs consecutive words into 128-bit beats.
- Pads the final partial beat of each transfer and stamps every beat with the transfer's 4-bit tag.
- Provides a one-beat output register with full-throughput backpressure.

Parameters:
- IN_W, 32, input word width; legal values 32 or 64.
- OUT_W, 128, output beat width; fixed to match the SoC-IT port.
- PAD_WORD, 0, value placed in unfilled lanes of a partial final beat (IN_W bits).

Ports:
- clk  input  1  single clock for all logic.
- rst  input  1  reset, asynchronous, active-low (rst=0 resets).
- in_src_rdy  input  1  input word valid.
- in_dst_rdy  output  1  packer can accept a word this cycle.
- in_data  input  IN_W  input word.
- in_last  input  1  word is the final word of the transfer.
- in_tag  input  4  transfer tag; sampled only on the first word of a transfer.
- master_datain_src_rdy  output  1  output beat valid.
- master_datain_dst_rdy  input  1  SoC-IT accepts the beat.
- master_datain_tag  output  4  tag of the current beat.
- master_datain  output  128  packed beat.
- xfer_done  output  1  one-cycle pulse when the last beat of a transfer is accepted downstream.
- beat_cnt  output  16  beats accepted downstream since reset; wraps at 0xFFFF->0.

Behaviour:
- Definitions:
  - LANES = OUT_W/IN_W (4 for IN_W=32, 2 for IN_W=64).
  - A word is accepted when in_src_rdy & in_dst_rdy.
  - A beat is accepted when master_datain_src_rdy & master_datain_dst_rdy.
- Reset (rst=0, async), cleared immediately:
  - All outputs to 0: in_dst_rdy, master_datain_src_rdy, master_datain_tag, master_datain, xfer_done, beat_cnt.
  - Lane counter and assembly register to 0; state to IDLE.
  - After rst deasserts, in_dst_rdy rises on the first clk edge.
- Reset mid-transfer discards any partial beat and any held output beat; nothing is replayed.
- in_dst_rdy = (not master_datain_src_rdy) or master_datain_dst_rdy, registered-state based.
  - It must not depend combinationally on in_src_rdy, in_data or in_last.
- States:
  - IDLE: no transfer open, lane=0.
  - PACK: transfer open, tag held in tag_q.
- IDLE, word accepted: tag_q <= in_tag.
  - If in_last: emit a one-lane beat and stay in IDLE.
  - Otherwise: store in lane 0, lane <= 1, go to PACK.
- PACK, word accepted: write into lane[lane].
  - If lane==LANES-1 or in_last: emit beat, lane <= 0.
  - Otherwise: lane++.
  - Goes to IDLE when the accepted word has in_last=1.
- in_tag is ignored in PACK.
- Lane order: word k of a beat occupies bits [IN_W*k+IN_W-1 : IN_W*k]; word 0 is least significant.
- Emit: the output register loads {completed lanes, PAD_WORD in unfilled lanes} on the accepting clk edge.
  - The beat appears next cycle, so word-to-beat latency is 1 cycle.
  - master_datain_tag = tag_q, or in_tag when the beat is emitted from IDLE.
  - The output register also records an internal last flag.
- Output valid and data stay stable until the beat is accepted.
  - Simultaneous accept of the held beat and emit of a new one loads the new beat with no bubble.
  - Sustained rate is one word per cycle, i.e. one beat per LANES cycles.
- xfer_done pulses for 1 cycle, on the cycle after the beat carrying the last flag is accepted downstream.
- beat_cnt increments by 1 per accepted beat.
- A transfer may be any length of 1 word or more; there is no maximum.
- Words never straddle transfers: a new transfer always starts at lane 0.
- in_src_rdy with in_dst_rdy=0 has no effect; the upstream engine holds its word.

Test Plan:
- IN_W=32, tag=5, words 0x11,0x22,0x33,0x44 (last on 0x44), dst_rdy=1 -> one beat 0x00000044_00000033_00000022_00000011, tag 5, xfer_done pulse, beat_cnt=1.
- 6-word transfer 1..6, tag=0xA, last on 6 -> beat0 = {4,3,2,1}, beat1 = {PAD,PAD,6,5}, both tag 0xA, xfer_done only after beat1 accepted.
- Single-word transfer 0xDEAD from IDLE with last, tag=3 -> beat {0,0,0,0xDEAD}, tag 3, state stays IDLE.
- dst_rdy held 0 for 10 cycles with a beat pending -> in_dst_rdy=0, master_datain stable, no word lost; release gives in-order beats with zero bubbles.
- Back-to-back transfers tag 1 (5 words) then tag 2 (3 words), dst_rdy=1 -> 3 beats tagged 1,1,2, second transfer starts at lane 0, beat_cnt=3.
- rst pulled low mid-beat after 2 words -> outputs zero immediately; after release a new 4-word transfer packs from lane 0 with no remnant data.
